// File: rtl/recur_decoder_pkg.sv
// recur_decoder_pkg: FSM state encoding, counter width and default run length
package recur_decoder_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;
  localparam int CNT_W = 7;
  localparam int N_DEF = 100;
endpackage

// File: rtl/recur_decoder_x_pipe_reg.sv
// x_pipe_reg: single-entry output register with valid/ready handshake
// ports: i_load/i_data capture a new result, i_ready consumes o_data,
//        o_free says a load may happen this cycle without losing o_data
module x_pipe_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic         o_free
);
  assign o_free = !o_valid || i_ready;
  always_ff @(posedge clk)
    if (rst) begin
      o_data  <= '0;
      o_valid <= 1'b0;
    end else if (i_load) begin
      o_data  <= i_data;
      o_valid <= 1'b1;
    end else if (i_ready)
      o_valid <= 1'b0;
endmodule

// File: rtl/recur_decoder.sv
// recur_decoder: inverts y(n) = 2*y(n-1) + x(n), emitting x(n) = y(n) - 2*y(n-1) mod 2^W
// ports: start begins a run of N samples; y_in/y_valid/y_ready is the input stream,
//        x_out/x_valid/x_ready the output stream; busy in RUN/DRAIN, done pulses at end,
//        cnt counts samples accepted in the current run
module recur_decoder
  import recur_decoder_pkg::*;
#(
  parameter int W = 32,
  parameter int N = N_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     y_in,
  input  logic             y_valid,
  output logic             y_ready,
  output logic [W-1:0]     x_out,
  output logic             x_valid,
  input  logic             x_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt
);
  // one extra bit so N = 128 is still reachable by the 7-bit counter
  localparam logic [CNT_W:0] N_L = (CNT_W+1)'(N);
  state_t           r_state;
  logic [W-1:0]     r_y_prev;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             w_free;
  logic             w_accept;
  logic             w_last;
  logic [W-1:0]     w_x;
  assign y_ready  = (r_state == S_RUN) && w_free;
  assign w_accept = y_valid && y_ready;
  assign w_x      = y_in - (r_y_prev << 1);
  assign w_last   = ({1'b0, r_cnt} + 1'b1) == N_L;
  assign busy     = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done     = r_done;
  assign cnt      = r_cnt;
  x_pipe_reg #(.W(W)) u_xreg (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept),
    .i_data (w_x),
    .i_ready(x_ready),
    .o_data (x_out),
    .o_valid(x_valid),
    .o_free (w_free)
  );
  always_ff @(posedge clk)
    if (rst) begin
      r_state  <= S_IDLE;
      r_y_prev <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE:
          if (start) begin
            r_state  <= S_RUN;
            r_y_prev <= '0;
            r_cnt    <= '0;
          end
        S_RUN:
          if (w_accept) begin
            r_y_prev <= y_in;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) r_state <= S_DRAIN;
          end
        S_DRAIN:
          if (!x_valid || x_ready) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        default: r_state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_recur_decoder.sv
// tb_recur_decoder: randomized and directed checks of recur_decoder against an encoder model
module tb_recur_decoder;
  localparam int W = 32;
  localparam int N = 100;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] y_in = '0;
  logic         y_valid = 1'b0;
  logic         y_ready;
  logic [W-1:0] x_out;
  logic         x_valid;
  logic         x_ready = 1'b0;
  logic         busy;
  logic         done;
  logic [6:0]   cnt;
  logic         start3 = 1'b0;
  logic [W-1:0] y3 = '0;
  logic         yv3 = 1'b0;
  logic         yr3;
  logic [W-1:0] x3;
  logic         xv3;
  logic         xr3 = 1'b1;
  logic         busy3;
  logic         done3;
  logic [6:0]   cnt3;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  recur_decoder #(.W(W), .N(N)) u_dut (
    .clk(clk), .rst(rst), .start(start), .y_in(y_in), .y_valid(y_valid), .y_ready(y_ready),
    .x_out(x_out), .x_valid(x_valid), .x_ready(x_ready), .busy(busy), .done(done), .cnt(cnt)
  );
  recur_decoder #(.W(W), .N(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .y_in(y3), .y_valid(yv3), .y_ready(yr3),
    .x_out(x3), .x_valid(xv3), .x_ready(xr3), .busy(busy3), .done(done3), .cnt(cnt3)
  );
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // extend a directed prefix to N samples by encoding random x values
  task automatic make_stream(input logic [W-1:0] py[$], input logic [W-1:0] px[$],
                             output logic [W-1:0] ys[$], output logic [W-1:0] xs[$]);
    logic [W-1:0] y;
    logic [W-1:0] x;
    ys = py;
    xs = px;
    y = (ys.size() > 0) ? ys[ys.size()-1] : '0;
    while (ys.size() < N) begin
      x = $urandom;
      y = 2 * y + x;
      ys.push_back(y);
      xs.push_back(x);
    end
  endtask
  task automatic run_seq(input logic [W-1:0] ys[$], input logic [W-1:0] xs[$],
                         input int rst_after, input bit bp, input bit poke);
    int acc = 0;
    int con = 0;
    int cyc = 0;
    int bp_left = 0;
    bit prev_acc = 0;
    bit done_seen = 0;
    bit bp_done = 0;
    logic [W-1:0] held = '0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("run_busy", busy, 1);
    check("run_cnt0", cnt, 0);
    while (!done_seen && cyc < 3000) begin
      if (prev_acc) check("latency1", x_valid, 1);
      check("cnt_track", cnt, acc);
      if (done) begin
        done_seen = 1;
        check("done_after_last", con, N);
      end else begin
        if (rst_after > 0 && acc == rst_after) begin
          rst = 1'b1; start = 1'b1; y_valid = 1'b1; x_ready = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0; start = 1'b0; y_valid = 1'b0;
          check("rst_xvalid", x_valid, 0);
          check("rst_cnt", cnt, 0);
          check("rst_busy", busy, 0);
          check("rst_yready", y_ready, 0);
          repeat (5) begin
            @(posedge clk); #1;
            check("rst_nodone", done, 0);
            check("rst_idle", busy, 0);
          end
          return;
        end
        start = poke && (acc == 10);
        if (bp && !bp_done && acc >= 30 && x_valid) begin
          bp_left = 4;
          bp_done = 1;
          held = x_out;
        end
        y_valid = (acc < N) ? ($urandom_range(3) != 0) : 1'b1;
        y_in = (acc < N) ? ys[acc] : $urandom;
        x_ready = (bp_left > 0) ? 1'b0 : ($urandom_range(3) != 0);
        #1;
        if (bp_left > 0) begin
          check("bp_yready", y_ready, 0);
          check("bp_hold", x_out, held);
          bp_left--;
        end
        if (acc >= N) check("drain_yready", y_ready, 0);
        prev_acc = y_valid && y_ready;
        if (x_valid && x_ready) begin
          if (con < N) check("x_out", x_out, xs[con]);
          else check("extra_output", 1, 0);
          con++;
        end
        if (prev_acc) acc++;
        @(posedge clk); #1;
      end
      cyc++;
    end
    start = 1'b0;
    y_valid = 1'b0;
    check("timeout", done_seen, 1);
    check("done_cnt", cnt, N);
    @(posedge clk); #1;
    check("done_pulse_end", done, 0);
    check("idle_busy", busy, 0);
    check("cnt_hold", cnt, N);
  endtask
  initial begin
    logic [W-1:0] py[$];
    logic [W-1:0] px[$];
    logic [W-1:0] ys[$];
    logic [W-1:0] xs[$];
    logic [W-1:0] d3[3];
    repeat (2) @(posedge clk);
    #1;
    check("reset_xvalid", x_valid, 0);
    check("reset_xout", x_out, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_cnt", cnt, 0);
    check("reset_yready", y_ready, 0);
    rst = 1'b0;
    // N=3 directed run: y = 3, 9, 21 decodes to 3, 3, 3
    d3[0] = 3; d3[1] = 9; d3[2] = 21;
    @(posedge clk); #1 start3 = 1'b1;
    @(posedge clk); #1 start3 = 1'b0;
    yv3 = 1'b1;
    check("n3_yready", yr3, 1);
    for (int k = 0; k < 3; k++) begin
      y3 = d3[k];
      @(posedge clk); #1;
      check("n3_xvalid", xv3, 1);
      check("n3_xout", x3, 3);
      check("n3_nodone", done3, 0);
    end
    y3 = 32'd99;
    check("n3_drain_yready", yr3, 0);
    check("n3_cnt", cnt3, 3);
    @(posedge clk); #1;
    check("n3_done", done3, 1);
    check("n3_xvalid_clr", xv3, 0);
    @(posedge clk); #1;
    yv3 = 1'b0;
    check("n3_done_once", done3, 0);
    check("n3_idle", busy3, 0);
    check("n3_cnt_hold", cnt3, 3);
    // random stream with backpressure window and stray start pulses
    make_stream(py, px, ys, xs);
    run_seq(ys, xs, 0, 1, 1);
    // wrap: 0 - 2*0x40000000 wraps to 0x80000000
    py = {32'h4000_0000, 32'h0000_0000};
    px = {32'h4000_0000, 32'h8000_0000};
    make_stream(py, px, ys, xs);
    run_seq(ys, xs, 0, 0, 0);
    // wrap: shifted 0x80000000 loses its MSB, so 5 decodes to 5
    py = {32'h8000_0000, 32'h0000_0005};
    px = {32'h8000_0000, 32'h0000_0005};
    make_stream(py, px, ys, xs);
    run_seq(ys, xs, 0, 0, 0);
    // reset after 50 accepts, then a fresh run from y(-1)=0
    py.delete();
    px.delete();
    make_stream(py, px, ys, xs);
    run_seq(ys, xs, 50, 0, 0);
    make_stream(py, px, ys, xs);
    run_seq(ys, xs, 0, 1, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/recur_decoder.md
RECUR_DECODER -- requirements
Module: recur_decoder

Interface
REQ-001 Parameter W, default 32, sample width in bits.
REQ-002 Parameter N, default 100, samples per run; 2 <= N <= 128.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 start  input  1  single-cycle request to begin a run; honoured only in IDLE.
REQ-006 y_in  input  W  encoded sample y(n).
REQ-007 y_valid  input  1  y_in is valid this cycle.
REQ-008 y_ready  output  1  block accepts y_in this cycle.
REQ-009 x_out  output  W  decoded sample x(n).
REQ-010 x_valid  output  1  x_out holds an unconsumed result.
REQ-011 x_ready  input  1  sink consumes x_out this cycle.
REQ-012 busy  output  1  high in RUN and DRAIN.
REQ-013 done  output  1  one-cycle pulse when a run completes.
REQ-014 cnt  output  7  number of samples accepted in the current run.

Function
REQ-015 The block SHALL invert the recurrence y(n) = 2*y(n-1) + x(n) by computing x(n) = y(n) - 2*y(n-1), with y(-1) = 0 at the start of every run.
REQ-016 All arithmetic SHALL be modulo 2^W: the shifted y(n-1) drops its MSB and the subtraction wraps, with no saturation and no overflow flag.
REQ-017 FSM states SHALL be IDLE, RUN, DRAIN and DONE.
REQ-018 IDLE: y_ready=0. If start=1: go to RUN, set y_prev=0 and cnt=0.
REQ-019 RUN: y_ready = !x_valid | x_ready, so the single output stage stalls under backpressure without losing data.
REQ-020 Accept happens when y_valid & y_ready: x_out <= y_in - (y_prev<<1), x_valid <= 1, y_prev <= y_in, cnt <= cnt+1.
REQ-021 Latency SHALL be exactly 1 cycle from accept to x_valid; sustained throughput SHALL be 1 sample/cycle while x_ready=1.
REQ-022 x_valid SHALL clear on x_valid & x_ready unless a new accept happens in the same cycle, in which case it stays set with the new value.
REQ-023 When the N-th sample is accepted (cnt reaches N), the FSM SHALL move to DRAIN and y_ready SHALL be 0 from the next cycle.
REQ-024 DRAIN: the FSM SHALL move to DONE once x_valid=0, or in the same cycle x_valid & x_ready occurs.
REQ-025 DONE SHALL last one cycle with done=1, then return to IDLE; cnt SHALL hold N until the next start.
REQ-026 start SHALL be ignored in RUN, DRAIN and DONE.
REQ-027 y_in SHALL be ignored whenever y_ready=0.

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL enter IDLE and set x_out=0, x_valid=0, y_prev=0, cnt=0, done=0, busy=0 and y_ready=0.
REQ-029 Reset mid-run SHALL discard any pending x_out, and no done pulse SHALL be generated.
REQ-030 rst SHALL take priority over start and over handshakes in the same cycle.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding constants, the counter width (7) and the default N.
REQ-032 The output register and its valid/ready logic SHALL be one sub-module, x_pipe_reg, parameterised by W.

Verification
REQ-033 Run with N=3, x_ready=1, y = 3, 9, 21: x_out = 3, 3, 3, each one cycle after accept; done pulses once; cnt=3.
REQ-034 Wrap test: y = 0x40000000 then 0x00000000: second x_out = 0x80000000; y = 0x80000000 then 0x00000005: second x_out = 0x00000005.
REQ-035 Backpressure: hold x_ready=0 for 4 cycles mid-run: y_ready=0 while full, x_out stable, no sample lost or duplicated, and the output sequence matches the reference model.
REQ-036 Default N=100 with an encoder-generated random stream: 100 correct x_out values; y_ready falls after the 100th accept; done asserts only after the last x_out is consumed.
REQ-037 Assert rst after 50 accepts: the next cycle shows IDLE, x_valid=0, cnt=0; no done pulse; a new start decodes correctly from y(-1)=0.
REQ-038 Pulse start during RUN: no effect, and cnt and y_prev are not disturbed.
